alu_result_fmt: RTL and testbench

- Formats a 16-bit ALU result into the 4-digit nibble word and per-digit enable mask consumed by the 8-digit seven-segment LUT stage.
- Supports two modes: hex pass-through, and unsigned decimal via a sequential double-dabble (shift-add-3) converter.
- Applies optional leading-zero blanking.
- Sits between the ALU result register and the display decoder; holds the last formatted value until a new conversion completes.

---
 rtl/alu_result_fmt.sv | 158 +++++++++++++++
 tb/tb_alu_result_fmt.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_fmt.sv
// ALU result formatter: hex pass-through or sequential double-dabble decimal, with leading-zero blanking.
// Hex done 1 cycle after iSTART, decimal 17; iSTART ignored while busy. Build option: SIGNED_DEC_EN.
module alu_result_fmt #(
    parameter int NDIG  = 4,
    parameter int WIDTH = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic [WIDTH-1:0] iVAL,
    input  logic             iMODE,
    input  logic             iLZB,
    output logic [15:0]      oDIG,
    output logic [7:0]       oON_OFF,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oOVF,
    output logic             oNEG
);
    localparam int BCDW = 20;
    localparam int CW   = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [BCDW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              lzb_q, lzb_d;
    logic              neg_q, neg_d;
    logic [15:0]       dig_q, dig_d;
    logic [7:0]        on_q, on_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              nego_q, nego_d;

    logic [WIDTH-1:0]      mag;
    logic                  neg_in;
    logic [BCDW-1:0]       adj;
    logic [BCDW+WIDTH-1:0] cat_sh;
    logic                  fmt_ovf;
    logic [15:0]           fmt_dig;
    logic [NDIG-1:0]       fmt_mask;

`ifdef SIGNED_DEC_EN
    // 16'h8000 negates to itself, which reads as 32768 and saturates naturally.
    assign neg_in = iMODE & iVAL[WIDTH-1];
    assign mag    = neg_in ? (~iVAL + 1'b1) : iVAL;
`else
    assign neg_in = 1'b0;
    assign mag    = iVAL;
`endif

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCDW / 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        cat_sh = {adj, sr_q} << 1;
    end

    // Decimal results take the accumulator; hex results are still sitting in the shift register.
    always_comb begin
        fmt_ovf = mode_q && (bcd_q[19:16] != 4'd0);
        if (!mode_q)
            fmt_dig = sr_q[15:0];
        else if (fmt_ovf)
            fmt_dig = 16'h9999;
        else
            fmt_dig = bcd_q[15:0];
        for (int k = 0; k < NDIG; k++)
            fmt_mask[k] = !lzb_q || (k == 0) || ((fmt_dig >> (4 * k)) != 16'd0);
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        lzb_d   = lzb_q;
        neg_d   = neg_q;
        dig_d   = dig_q;
        on_d    = on_q;
        ovf_d   = ovf_q;
        nego_d  = nego_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    mode_d  = iMODE;
                    lzb_d   = iLZB;
                    neg_d   = neg_in;
                    sr_d    = iMODE ? mag : iVAL;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = iMODE ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                bcd_d = cat_sh[BCDW+WIDTH-1:WIDTH];
                sr_d  = cat_sh[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = DONE;
            end
            DONE: begin
                dig_d   = fmt_dig;
                on_d    = {{(8 - NDIG){1'b0}}, fmt_mask};
                ovf_d   = fmt_ovf;
                nego_d  = mode_q & neg_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            lzb_q   <= 1'b0;
            neg_q   <= 1'b0;
            dig_q   <= 16'h0000;
            on_q    <= 8'h01;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            nego_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            lzb_q   <= lzb_d;
            neg_q   <= neg_d;
            dig_q   <= dig_d;
            on_q    <= on_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            nego_q  <= nego_d;
        end
    end

    assign oDIG    = dig_q;
    assign oON_OFF = on_q;
    assign oBUSY   = (state_q != IDLE);
    assign oDONE   = done_q;
    assign oOVF    = ovf_q;
    assign oNEG    = nego_q;

endmodule

// File: tb/tb_alu_result_fmt.sv
// Randomized bench for alu_result_fmt against an arithmetic reference model.
module tb_alu_result_fmt;
    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSTART;
    logic [15:0] iVAL;
    logic        iMODE;
    logic        iLZB;
    logic [15:0] oDIG;
    logic [7:0]  oON_OFF;
    logic        oBUSY;
    logic        oDONE;
    logic        oOVF;
    logic        oNEG;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 iCLK = ~iCLK;

    alu_result_fmt #(.NDIG(4), .WIDTH(16)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iVAL(iVAL), .iMODE(iMODE), .iLZB(iLZB),
        .oDIG(oDIG), .oON_OFF(oON_OFF), .oBUSY(oBUSY), .oDONE(oDONE), .oOVF(oOVF), .oNEG(oNEG)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: digits from division, lit-digit count from the numeric magnitude of the word.
    task automatic model(input logic [15:0] v, input logic m, input logic z,
                         output logic [15:0] ed, output logic [7:0] eo,
                         output logic eovf, output logic eneg);
        int mag;
        int n;
        eneg = 1'b0;
        eovf = 1'b0;
        if (!m) begin
            ed = v;
        end else begin
            mag = int'(v);
`ifdef SIGNED_DEC_EN
            if (v >= 16'h8000) begin
                eneg = 1'b1;
                mag  = 65536 - int'(v);
            end
`endif
            if (mag > 9999) begin
                ed   = 16'h9999;
                eovf = 1'b1;
            end else begin
                ed = 16'((mag / 1000) % 10 * 4096 + (mag / 100) % 10 * 256 + (mag / 10) % 10 * 16 + mag % 10);
            end
        end
        n = 1;
        if (ed >= 16'h0010) n = 2;
        if (ed >= 16'h0100) n = 3;
        if (ed >= 16'h1000) n = 4;
        eo = z ? 8'((1 << n) - 1) : 8'h0F;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dig"},  32'(oDIG),    32'h0000);
        check({tag, "_on"},   32'(oON_OFF), 32'h01);
        check({tag, "_busy"}, 32'(oBUSY),   32'h0);
        check({tag, "_done"}, 32'(oDONE),   32'h0);
        check({tag, "_ovf"},  32'(oOVF),    32'h0);
        check({tag, "_neg"},  32'(oNEG),    32'h0);
    endtask

    task automatic do_conv(input logic [15:0] v, input logic m, input logic z);
        logic [15:0] ed;
        logic [7:0]  eo;
        logic        eovf, eneg;
        int          cyc;
        model(v, m, z, ed, eo, eovf, eneg);
        @(negedge iCLK);
        iSTART = 1'b1; iVAL = v; iMODE = m; iLZB = z;
        @(posedge iCLK); #1;
        iSTART = 1'b0; iVAL = 16'($urandom); iMODE = ~m; iLZB = ~z;
        cyc = 0;
        while (!oDONE && cyc < 40) begin
            check("busy", 32'(oBUSY), 32'h1);
            @(posedge iCLK); #1;
            cyc++;
        end
        check("latency", 32'(cyc), m ? 32'd17 : 32'd1);
        check("dig",  32'(oDIG),    32'(ed));
        check("on",   32'(oON_OFF), 32'(eo));
        check("ovf",  32'(oOVF),    32'(eovf));
        check("neg",  32'(oNEG),    32'(eneg));
        check("idle", 32'(oBUSY),   32'h0);
        @(posedge iCLK); #1;
        check("done_pulse", 32'(oDONE), 32'h0);
    endtask

    initial begin
        logic [15:0] ed;
        logic [7:0]  eo;
        logic        eovf, eneg;
        logic [15:0] v;
        int          done_cnt;

        iRST = 1'b1; iSTART = 1'b0; iVAL = '0; iMODE = 1'b0; iLZB = 1'b0;
        repeat (3) @(posedge iCLK);
        #1 check_reset_vals("rst_hold");
        @(negedge iCLK) iRST = 1'b0;
        @(posedge iCLK); #1 check_reset_vals("rst_rel");

        do_conv(16'h00A5, 1'b0, 1'b1);
        do_conv(16'd1234, 1'b1, 1'b0);
        do_conv(16'hFFFF, 1'b1, 1'b0);
        do_conv(16'd0,    1'b1, 1'b1);
        do_conv(16'd9999, 1'b1, 1'b1);
        do_conv(16'd10000, 1'b1, 1'b1);
        do_conv(16'd7,    1'b1, 1'b1);
        do_conv(16'hFF85, 1'b1, 1'b1);
        do_conv(16'h8000, 1'b1, 1'b0);
        do_conv(16'h0000, 1'b0, 1'b1);
        do_conv(16'hF000, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 1) == 1) v = 16'($urandom_range(0, 12000));
            do_conv(v, 1'($urandom), 1'($urandom));
        end

        // Second request mid-conversion must be dropped.
        model(16'd4321, 1'b1, 1'b0, ed, eo, eovf, eneg);
        @(negedge iCLK);
        iSTART = 1'b1; iVAL = 16'd4321; iMODE = 1'b1; iLZB = 1'b0;
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                iSTART = 1'b1; iVAL = 16'h0042; iMODE = 1'b0; iLZB = 1'b1;
            end
            if (c == 6) iSTART = 1'b0;
            @(posedge iCLK); #1;
            if (oDONE) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("ovl_latency", 32'(c), 32'd17);
                    check("ovl_dig", 32'(oDIG), 32'(ed));
                    check("ovl_on",  32'(oON_OFF), 32'(eo));
                end
            end
        end
        check("ovl_done_cnt", 32'(done_cnt), 32'd1);

        // Reset in the middle of a conversion aborts it without a completion.
        @(negedge iCLK);
        iSTART = 1'b1; iVAL = 16'd5678; iMODE = 1'b1; iLZB = 1'b1;
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        repeat (8) @(posedge iCLK);
        #1 iRST = 1'b1;
        #1 check_reset_vals("abort");
        @(negedge iCLK) iRST = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge iCLK); #1;
            if (oDONE) done_cnt++;
        end
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check_reset_vals("abort_after");

        do_conv(16'd42, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
